// File: rtl/lut_fractured_chain.sv
`default_nettype none
// ============================================================================
// Module   : lut_fractured_chain
// Purpose  : Fractured LUT with a double-buffered, word-serial configuration
//            path. The LUT exposes one full-width output and 2**FRACTURING
//            sub-LUT outputs. Config words are shifted into a shadow
//            register. The shadow register is then committed atomically to the
//            active table, so lookups never observe a partially loaded table.
//            Bits that are shifted out of the shadow register go to cfg_out,
//            where the next LUT in a chain can pick them up.
// Ports    : config_clk    - clock, rising edge
//            config_rst    - asynchronous active-high reset
//            addr          - LUT address (INPUTS bits)
//            full_out      - active[addr]
//            frac_out      - one bit per sub-LUT, addressed by the low bits
//            cfg_start     - begin or restart a load
//            cfg_valid     - cfg_data holds a word
//            cfg_ready     - high while the block accepts words
//            cfg_data      - config word; the first word lands in the low bits
//            cfg_out       - word shifted out of the shadow register
//            cfg_out_valid - cfg_out was updated by this cycle's accept
//            cfg_done      - one-cycle pulse after a commit
//            cfg_loaded    - a table has been committed since reset
// Revision : 1.0 - initial release
// ============================================================================
module lut_fractured_chain #(
  parameter int INPUTS     = 5,
  parameter int FRACTURING = 1,
  parameter int CFG_WIDTH  = 4
) (
  input  logic                        config_clk,
  input  logic                        config_rst,
  input  logic [INPUTS-1:0]           addr,
  output logic                        full_out,
  output logic [(2**FRACTURING)-1:0]  frac_out,
  input  logic                        cfg_start,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CFG_WIDTH-1:0]        cfg_data,
  output logic [CFG_WIDTH-1:0]        cfg_out,
  output logic                        cfg_out_valid,
  output logic                        cfg_done,
  output logic                        cfg_loaded
);

  localparam int MEM_SIZE = 2 ** INPUTS;
  localparam int NWORDS   = MEM_SIZE / CFG_WIDTH;
  localparam int SUB      = MEM_SIZE >> FRACTURING;
  localparam int SUB_W    = INPUTS - FRACTURING;
  localparam int NFRAC    = 2 ** FRACTURING;
  localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [MEM_SIZE-1:0] r_active;
  logic [MEM_SIZE-1:0] r_shadow;
  logic [CNT_W-1:0]    r_count;
  logic [MEM_SIZE-1:0] w_shadow_next;

  // New words enter at the top, so after NWORDS accepts the first word has
  // walked down into the least significant slot.
  if (NWORDS == 1) begin : g_single_word
    assign w_shadow_next = cfg_data;
  end else begin : g_multi_word
    assign w_shadow_next = {cfg_data, r_shadow[MEM_SIZE-1:CFG_WIDTH]};
  end

  // Lookups read the active table only. The shadow table never reaches these
  // outputs.
  assign full_out = r_active[addr];

  for (genvar k = 0; k < NFRAC; k++) begin : g_frac
    localparam logic [INPUTS-1:0] C_BASE = INPUTS'(k * SUB);
    logic [INPUTS-1:0] w_index;
    assign w_index     = C_BASE | INPUTS'(addr[SUB_W-1:0]);
    assign frac_out[k] = r_active[w_index];
  end

  assign cfg_ready = (r_state == S_LOAD);

  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      r_state       <= S_IDLE;
      r_active      <= '0;
      r_shadow      <= '0;
      r_count       <= '0;
      cfg_out       <= '0;
      cfg_out_valid <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_loaded    <= 1'b0;
    end else begin
      cfg_out_valid <= 1'b0;
      cfg_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          // A restart takes priority over a word offered in the same cycle.
          // The word is dropped and the shadow register keeps its contents.
          if (cfg_start) begin
            r_count <= '0;
          end else if (cfg_valid) begin
            r_shadow      <= w_shadow_next;
            cfg_out       <= r_shadow[CFG_WIDTH-1:0];
            cfg_out_valid <= 1'b1;
            r_count       <= r_count + 1'b1;
            if (r_count == CNT_W'(NWORDS - 1)) begin
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_active   <= r_shadow;
          cfg_done   <= 1'b1;
          cfg_loaded <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_fractured_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_fractured_chain
// Purpose  : Self-checking bench for lut_fractured_chain with INPUTS=4,
//            FRACTURING=1 and CFG_WIDTH=4. The reference model tracks
//            accepted words as a history queue and builds the table from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_fractured_chain;

  logic       config_clk = 1'b0;
  logic       config_rst = 1'b1;
  logic [3:0] addr       = '0;
  logic       full_out;
  logic [1:0] frac_out;
  logic       cfg_start  = 1'b0;
  logic       cfg_valid  = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_data   = '0;
  logic [3:0] cfg_out;
  logic       cfg_out_valid;
  logic       cfg_done;
  logic       cfg_loaded;

  lut_fractured_chain #(
    .INPUTS    (4),
    .FRACTURING(1),
    .CFG_WIDTH (4)
  ) dut (
    .config_clk   (config_clk),
    .config_rst   (config_rst),
    .addr         (addr),
    .full_out     (full_out),
    .frac_out     (frac_out),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_out      (cfg_out),
    .cfg_out_valid(cfg_out_valid),
    .cfg_done     (cfg_done),
    .cfg_loaded   (cfg_loaded)
  );

  always #5 config_clk = ~config_clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [3:0] chain_q[$];

  // Reference model: phase 0 = idle, 1 = loading, 2 = commit pending.
  int         m_phase;
  int         m_cnt;
  logic [3:0] m_hist[$];   // last four accepted words, oldest first
  logic [15:0] m_active;
  logic       m_done, m_loaded, m_ov;
  logic [3:0] m_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] expected_vec(input logic [3:0] a);
    logic [1:0] f;
    for (int k = 0; k < 2; k++) f[k] = m_active[k * 8 + int'(a[2:0])];
    return {(m_phase == 1), m_done, m_loaded, m_ov, m_out, m_active[a], f};
  endfunction

  function automatic logic [10:0] actual_vec();
    return {cfg_ready, cfg_done, cfg_loaded, cfg_out_valid, cfg_out, full_out, frac_out};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_cnt    = 0;
    m_hist   = '{4'h0, 4'h0, 4'h0, 4'h0};
    m_active = '0;
    m_done   = 1'b0;
    m_loaded = 1'b0;
    m_ov     = 1'b0;
    m_out    = '0;
  endtask

  task automatic model_edge(input bit s, input bit v, input logic [3:0] d);
    m_done = 1'b0;
    m_ov   = 1'b0;
    case (m_phase)
      0: if (s) begin m_phase = 1; m_cnt = 0; end
      1: begin
        if (s) m_cnt = 0;
        else if (v) begin
          m_out = m_hist.pop_front();
          m_hist.push_back(d);
          m_ov = 1'b1;
          m_cnt++;
          if (m_cnt == 4) m_phase = 2;
        end
      end
      default: begin
        m_active = {m_hist[3], m_hist[2], m_hist[1], m_hist[0]};
        m_done   = 1'b1;
        m_loaded = 1'b1;
        m_phase  = 0;
      end
    endcase
  endtask

  // Drive one cycle of inputs, then check every output against the model.
  task automatic step(input bit s, input bit v, input logic [3:0] d,
                      input logic [3:0] a, input string name);
    cfg_start = s;
    cfg_valid = v;
    cfg_data  = d;
    addr      = a;
    @(posedge config_clk);
    #1;
    model_edge(s, v, d);
    if (cfg_done) done_seen++;
    if (cfg_out_valid) chain_q.push_back(cfg_out);
    check(name, 32'(actual_vec()), 32'(expected_vec(a)));
  endtask

  task automatic do_reset(input string name);
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    config_rst = 1'b1;
    #1;
    model_reset();
    check(name, 32'(actual_vec()), 32'(expected_vec(addr)));
    @(posedge config_clk);
    #1;
    config_rst = 1'b0;
  endtask

  task automatic load16(input logic [15:0] val, input logic [3:0] a, input string name);
    step(1'b1, 1'b0, 4'h0, a, name);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, val[i*4 +: 4], a, name);
    step(1'b0, 1'b0, 4'h0, a, name);
  endtask

  typedef struct {
    logic [3:0] a;
    logic       full;
    logic [1:0] frac;
  } lookup_t;

  lookup_t tbl[7];
  logic [3:0] exp_chain[4];

  initial begin
    tbl[0] = '{4'd0,  1'b1, 2'b11};
    tbl[1] = '{4'd5,  1'b1, 2'b01};
    tbl[2] = '{4'd15, 1'b0, 2'b00};
    tbl[3] = '{4'd9,  1'b1, 2'b10};
    tbl[4] = '{4'd14, 1'b1, 2'b10};
    tbl[5] = '{4'd1,  1'b0, 2'b10};
    tbl[6] = '{4'd8,  1'b1, 2'b11};
    exp_chain = '{4'h1, 4'h2, 4'h3, 4'h4};

    model_reset();
    repeat (2) @(posedge config_clk);
    #1;
    config_rst = 1'b0;
    do_reset("reset_state");

    // Reset in the middle of a load discards the partial load.
    step(1'b1, 1'b0, 4'h0, 4'h0, "rst_load");
    step(1'b0, 1'b1, 4'h7, 4'h0, "rst_load");
    step(1'b0, 1'b1, 4'h8, 4'h0, "rst_load");
    do_reset("rst_mid_load");
    step(1'b1, 1'b0, 4'h0, 4'h0, "rst_reload");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'(i + 9), 4'h0, "rst_reload");
    step(1'b0, 1'b0, 4'h0, 4'h0, "rst_reload");
    check("rst_not_loaded", 32'(cfg_loaded), 32'd0);
    check("rst_still_ready", 32'(cfg_ready), 32'd1);
    step(1'b0, 1'b1, 4'hC, 4'h0, "rst_reload");
    step(1'b0, 1'b0, 4'h0, 4'h0, "rst_reload");
    check("rst_loaded", 32'(cfg_loaded), 32'd1);

    // Basic load of 16'h4321 with a single done pulse.
    done_seen = 0;
    load16(16'h4321, 4'h0, "load");
    step(1'b0, 1'b0, 4'h0, 4'h0, "load_idle");
    check("load_done_once", 32'(done_seen), 32'd1);
    check("load_loaded", 32'(cfg_loaded), 32'd1);

    // Lookup table on 16'h4321.
    for (int i = 0; i < 7; i++) begin
      addr = tbl[i].a;
      #1;
      check($sformatf("lookup_full_a%0d", tbl[i].a), 32'(full_out), 32'(tbl[i].full));
      check($sformatf("lookup_frac_a%0d", tbl[i].a), 32'(frac_out), 32'(tbl[i].frac));
    end

    // Reload 16'hFFFF with gaps: addr 15 must hold 0 until the commit.
    step(1'b1, 1'b0, 4'h0, 4'hF, "glitch");
    step(1'b0, 1'b1, 4'hF, 4'hF, "glitch");
    step(1'b0, 1'b0, 4'h0, 4'hF, "glitch");
    step(1'b0, 1'b0, 4'h0, 4'hF, "glitch");
    step(1'b0, 1'b1, 4'hF, 4'hF, "glitch");
    step(1'b0, 1'b0, 4'h0, 4'hF, "glitch");
    step(1'b0, 1'b1, 4'hF, 4'hF, "glitch");
    step(1'b0, 1'b1, 4'hF, 4'hF, "glitch");
    check("glitch_pre_commit", 32'(full_out), 32'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, "glitch");
    check("glitch_post_commit", 32'(full_out), 32'd1);

    // Restart after two words, restart has a word alongside it.
    done_seen = 0;
    step(1'b1, 1'b0, 4'h0, 4'h3, "restart");
    step(1'b0, 1'b1, 4'h6, 4'h3, "restart");
    step(1'b0, 1'b1, 4'h7, 4'h3, "restart");
    step(1'b1, 1'b1, 4'hE, 4'h3, "restart");
    step(1'b0, 1'b1, 4'h3, 4'h3, "restart");
    step(1'b0, 1'b1, 4'hC, 4'h3, "restart");
    step(1'b0, 1'b1, 4'h5, 4'h3, "restart");
    check("restart_no_early_commit", 32'(cfg_ready), 32'd1);
    step(1'b0, 1'b1, 4'hA, 4'h3, "restart");
    step(1'b0, 1'b0, 4'h0, 4'h3, "restart");
    step(1'b0, 1'b0, 4'h0, 4'h3, "restart");
    check("restart_done_once", 32'(done_seen), 32'd1);

    // Chain output: reload over 16'h4321 shifts its words out in order.
    load16(16'h4321, 4'h0, "chain_first");
    chain_q.delete();
    load16(16'h0000, 4'h0, "chain_second");
    check("chain_count", 32'(chain_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < chain_q.size())
        check($sformatf("chain_word%0d", i), 32'(chain_q[i]), 32'(exp_chain[i]));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)),
             4'($urandom), 4'($urandom), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
